reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 15 +
 rtl/reg_busy_cell.sv | 31 +++
 rtl/reg_scoreboard.sv | 77 +++++++
 tb/tb_reg_scoreboard.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU definitions: write-latency encodings and scoreboard defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package reg_scoreboard_pkg;

    // Default width of the write-latency field; max trackable latency is 2**W-1.
    localparam int unsigned LAT_W_DEF = 2;

    // Cycles until a producer's result can be forwarded to a consumer.
    localparam logic [LAT_W_DEF-1:0] LAT_ALU    = 2'd0;
    localparam logic [LAT_W_DEF-1:0] LAT_LOAD   = 2'd1;
    localparam logic [LAT_W_DEF-1:0] LAT_CP0    = 2'd1;
    localparam logic [LAT_W_DEF-1:0] LAT_MULDIV = 2'd3;

endpackage

// File: rtl/reg_busy_cell.sv
// Per-register busy countdown: load on issue, count down to zero, hold on stall.
// Latency: loaded value visible one cycle after the load edge.
// Backpressure: hold freezes the count, including a pending load.
module reg_busy_cell #(
    parameter int LAT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);

    // Priority: reset, flush, hold, load, then saturating decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (!hold) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// GPR hazard scoreboard: tracks in-flight write latencies, flags RAW/WAW stalls.
// Latency: hazard outputs combinational from current counts; issue visible next cycle.
// Backpressure: stall_req holds ID; stall_in freezes all counts and blocks issue.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int REG_NUM    = 32,
    parameter int ADDR_W     = 5,
    parameter int READ_PORTS = 2,
    parameter int LAT_W      = LAT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall_in,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [READ_PORTS-1:0]        read_en,
    input  logic [READ_PORTS*ADDR_W-1:0] read_addr,
    input  logic                         write_en,
    input  logic [ADDR_W-1:0]            write_addr,
    input  logic [LAT_W-1:0]             write_lat,
    output logic                         stall_req,
    output logic [READ_PORTS-1:0]        read_ready,
    output logic [REG_NUM-1:0]           busy_mask
);

    // Register 0 never tracks a write, so its count is tied to zero.
    logic [REG_NUM-1:0][LAT_W-1:0] cnt;
    logic                          accept;
    logic                          waw_hazard;
    logic [ADDR_W-1:0]             src;

    assign cnt[0] = '0;

    genvar i;
    generate
        for (i = 1; i < REG_NUM; i++) begin : g_cell
            reg_busy_cell #(
                .LAT_W    (LAT_W)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .hold     (stall_in),
                .load     (accept && write_en && (write_addr == ADDR_W'(i))),
                .load_val (write_lat),
                .cnt      (cnt[i])
            );
        end
    endgenerate

    // Busy bit per register is simply a nonzero countdown.
    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    // Per-port RAW check against pre-issue counts; disabled ports read as ready.
    always_comb begin
        read_ready = '1;
        src        = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            src           = read_addr[p*ADDR_W +: ADDR_W];
            read_ready[p] = !(read_en[p] && (src != '0) && (cnt[src] != '0));
        end
    end

    // A new write may not complete before an older write to the same register.
    always_comb begin
        waw_hazard = write_en && (write_addr != '0) && (cnt[write_addr] > write_lat);
        stall_req  = issue_valid && (!(&read_ready) || waw_hazard);
        accept     = issue_valid && !stall_req && !stall_in && !flush;
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard.
// Latency: expectations checked 2 time units after each negedge drive.
// Backpressure: exercises stall_in freeze, WAW stall and load-use stall.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic [1:0]  read_en = '0;
    logic [9:0]  read_addr = '0;
    logic        write_en = 1'b0;
    logic [4:0]  write_addr = '0;
    logic [1:0]  write_lat = '0;
    logic        stall_req;
    logic [1:0]  read_ready;
    logic [31:0] busy_mask;

    logic [31:0] exp_q[$];
    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .REG_NUM    (32),
        .ADDR_W     (5),
        .READ_PORTS (2),
        .LAT_W      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .flush       (flush),
        .issue_valid (issue_valid),
        .read_en     (read_en),
        .read_addr   (read_addr),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_lat   (write_lat),
        .stall_req   (stall_req),
        .read_ready  (read_ready),
        .busy_mask   (busy_mask)
    );

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        total++;
        if (exp_q.size() == 0) begin
            failed++;
            $error("FAIL %s: observed=%h but scoreboard empty", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) passed++;
            else begin
                failed++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
            end
        end
    endtask

    // Apply one cycle of inputs at the falling edge.
    task automatic drive(input logic r, input logic s, input logic f,
                         input logic iv, input logic [1:0] re,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic we, input logic [4:0] wa, input logic [1:0] wl);
        @(negedge clk);
        rst         = r;
        stall_in    = s;
        flush       = f;
        issue_valid = iv;
        read_en     = re;
        read_addr   = {a1, a0};
        write_en    = we;
        write_addr  = wa;
        write_lat   = wl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0);
    endtask

    function automatic logic [31:0] bit_of(input int n);
        logic [31:0] v;
        v = 32'd1 << n;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while an instruction with hazards-to-be is presented.
        drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0);
        drive(1, 1, 1, 1, 2'b11, 9, 3, 1, 4, LAT_MULDIV);
        push(32'h0); push(32'h3); push(32'h0);
        #2;
        check("rst_busy",  busy_mask);
        check("rst_ready", {30'b0, read_ready});
        check("rst_stall", {31'b0, stall_req});
        idle();
        push(32'h0);
        #2;
        check("rst_beats_issue", busy_mask);

        // Load-use: lw $t1, then addu reading $t1 stalls one cycle.
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 9, LAT_LOAD);
        push(32'h0);
        #2;
        check("lw_stall", {31'b0, stall_req});
        drive(0, 0, 0, 1, 2'b01, 9, 9, 1, 11, LAT_ALU);
        push(bit_of(9)); push(32'h2); push(32'h1);
        #2;
        check("lu_busy",  busy_mask);
        check("lu_ready", {30'b0, read_ready});
        check("lu_stall", {31'b0, stall_req});
        drive(0, 0, 0, 1, 2'b01, 9, 9, 1, 11, LAT_ALU);
        push(32'h0); push(32'h3);
        #2;
        check("lu_accept_stall", {31'b0, stall_req});
        check("lu_accept_ready", {30'b0, read_ready});
        idle();
        push(32'h0);
        #2;
        check("lu_after_busy", busy_mask);

        // ALU back-to-back on $t2.
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 10, LAT_ALU);
        push(32'h0);
        #2;
        check("alu_w_stall", {31'b0, stall_req});
        drive(0, 0, 0, 1, 2'b10, 0, 10, 0, 0, 2'd0);
        push(32'h0); push(32'h0);
        #2;
        check("alu_r_stall", {31'b0, stall_req});
        check("alu_r_busy",  busy_mask);

        // Register 0 is never tracked.
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 0, LAT_MULDIV);
        push(32'h0);
        #2;
        check("r0_w_stall", {31'b0, stall_req});
        drive(0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 2'd0);
        push(32'h0); push(32'h0); push(32'h3);
        #2;
        check("r0_busy",  busy_mask);
        check("r0_stall", {31'b0, stall_req});
        check("r0_ready", {30'b0, read_ready});

        // Self dependency addiu $t0,$t0 with latency 2 does not stall itself.
        drive(0, 0, 0, 1, 2'b01, 8, 0, 1, 8, 2'd2);
        push(32'h0);
        #2;
        check("self_stall", {31'b0, stall_req});

        // Freeze: three stall_in cycles, with an issue to $12 that must not load.
        drive(0, 1, 0, 1, 2'b00, 0, 0, 1, 12, LAT_MULDIV);
        push(bit_of(8)); push(32'h0);
        #2;
        check("frz_busy0",  busy_mask);
        check("frz_stallq", {31'b0, stall_req});
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'd0);
            push(bit_of(8));
            #2;
            check("frz_busy_hold", busy_mask);
        end
        idle();
        push(bit_of(8));
        #2;
        check("frz_release0", busy_mask);
        idle();
        push(bit_of(8));
        #2;
        check("frz_release1", busy_mask);
        idle();
        push(32'h0);
        #2;
        check("frz_release2", busy_mask);

        // WAW: cnt[9]=3, new write with latency 1 waits until cnt[9]<=1.
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 9, LAT_MULDIV);
        push(32'h0);
        #2;
        check("waw_first", {31'b0, stall_req});
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 9, LAT_LOAD);
        push(32'h1); push(bit_of(9));
        #2;
        check("waw_stall3", {31'b0, stall_req});
        check("waw_busy3",  busy_mask);
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 9, LAT_LOAD);
        push(32'h1);
        #2;
        check("waw_stall2", {31'b0, stall_req});
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 9, LAT_LOAD);
        push(32'h0);
        #2;
        check("waw_accept", {31'b0, stall_req});
        idle();
        push(bit_of(9));
        #2;
        check("waw_load_wins", busy_mask);
        idle();
        push(32'h0);
        #2;
        check("waw_done", busy_mask);

        // Flush overrides stall_in and a simultaneous issue.
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 6, LAT_MULDIV);
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 5, LAT_MULDIV);
        push(32'h0);
        #2;
        check("fl_setup_stall", {31'b0, stall_req});
        drive(0, 1, 1, 1, 2'b00, 0, 0, 1, 7, LAT_MULDIV);
        push(bit_of(5) | bit_of(6));
        #2;
        check("fl_before", busy_mask);
        drive(0, 0, 0, 1, 2'b11, 5, 6, 0, 0, 2'd0);
        push(32'h0); push(32'h0); push(32'h3);
        #2;
        check("fl_busy",  busy_mask);
        check("fl_stall", {31'b0, stall_req});
        check("fl_ready", {30'b0, read_ready});

        // Reset mid-countdown discards everything in one cycle.
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 6, LAT_MULDIV);
        drive(0, 0, 0, 1, 2'b00, 0, 0, 1, 5, LAT_MULDIV);
        drive(1, 1, 0, 1, 2'b00, 0, 0, 1, 7, LAT_MULDIV);
        push(bit_of(5) | bit_of(6));
        #2;
        check("rs_before", busy_mask);
        drive(0, 0, 0, 1, 2'b11, 5, 6, 0, 0, 2'd0);
        push(32'h0); push(32'h0);
        #2;
        check("rs_busy",  busy_mask);
        check("rs_stall", {31'b0, stall_req});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
